// File: rtl/typewriter_output_pkg.sv
// Shared definitions for the typewriter output path: FIO-DEC control codes,
// ASCII control bytes and the character-handling FSM states.
package typewriter_output_pkg;

  localparam logic [5:0] FD_SPACE = 6'o00;
  localparam logic [5:0] FD_TAB   = 6'o36;
  localparam logic [5:0] FD_BS    = 6'o75;
  localparam logic [5:0] FD_CR    = 6'o77;
  localparam logic [5:0] FD_LOWER = 6'o72;
  localparam logic [5:0] FD_UPPER = 6'o74;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Value of the enable input that selects the teletype as output device.
  localparam logic OUTPUT_TELETYPE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_PUSH    = 3'd2,
    ST_PUSH_LF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/typewriter_output_fiodec_to_ascii.sv
// Combinational FIO-DEC to ASCII table; mapped=0 flags codes with no printable
// or control equivalent (including the case-shift codes themselves).
module fiodec_to_ascii
  import typewriter_output_pkg::*;
(
  input  logic [5:0] code,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       mapped
);

  // Letters share one rule: case base plus offset within the code run.
  always_comb begin
    ascii  = 8'h00;
    mapped = 1'b1;
    case (code) inside
      FD_SPACE: ascii = 8'h20;
      FD_TAB:   ascii = 8'h09;
      FD_BS:    ascii = 8'h08;
      FD_CR:    ascii = ASCII_CR;
      6'o56:    ascii = 8'h7C;
      6'o20:    ascii = upper ? 8'h60 : 8'h30;
      [6'o01:6'o11]: begin
        if (upper) begin
          case (code[3:0])
            4'd1:    ascii = 8'h22;
            4'd2:    ascii = 8'h27;
            4'd3:    ascii = 8'h7E;
            4'd4:    ascii = 8'h23;
            4'd5:    ascii = 8'h21;
            4'd6:    ascii = 8'h26;
            4'd7:    ascii = 8'h3C;
            4'd8:    ascii = 8'h3E;
            default: ascii = 8'h5E;
          endcase
        end else begin
          ascii = 8'h30 + {2'b00, code};
        end
      end
      [6'o61:6'o71]: ascii = (upper ? 8'h41 : 8'h61) + {2'b00, code - 6'o61};
      [6'o41:6'o51]: ascii = (upper ? 8'h4A : 8'h6A) + {2'b00, code - 6'o41};
      [6'o22:6'o31]: ascii = (upper ? 8'h53 : 8'h73) + {2'b00, code - 6'o22};
      6'o33: ascii = upper ? 8'h3D : 8'h2C;
      6'o21: ascii = upper ? 8'h3F : 8'h2F;
      6'o57: ascii = upper ? 8'h5B : 8'h28;
      6'o55: ascii = upper ? 8'h5D : 8'h29;
      6'o73: ascii = upper ? 8'h2A : 8'h2E;
      6'o54: ascii = upper ? 8'h2B : 8'h2D;
      6'o40: ascii = upper ? 8'h5F : 8'h40;
      default: begin
        ascii  = 8'h00;
        mapped = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/typewriter_output.sv
// Typewriter output: decodes CPU tyo characters to ASCII, tracks shift state,
// expands carriage return and queues bytes for the teletype renderer.
module typewriter_output
  import typewriter_output_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit CRLF       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [5:0]                    tyo_char,
  input  logic                          tyo_strobe,
  output logic                          tyo_busy,
  output logic                          tyo_done,
  input  logic                          enable,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          upper_case,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  state_t          r_state;
  logic [5:0]      r_char;
  logic [7:0]      r_byte;
  logic            r_upper;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_count;
  logic [7:0]      r_out_data;
  logic            r_out_valid;

  logic [7:0]      w_ascii;
  logic            w_mapped;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_push_data;
  logic [AW-1:0]   w_rd_next;
  logic [LW-1:0]   w_count_next;

  fiodec_to_ascii u_table (
    .code   (r_char),
    .upper  (r_upper),
    .ascii  (w_ascii),
    .mapped (w_mapped)
  );

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign w_full      = (r_count == LW'(FIFO_DEPTH));
  assign w_push      = ((r_state == ST_PUSH) || (r_state == ST_PUSH_LF)) && !w_full;
  assign w_push_data = (r_state == ST_PUSH_LF) ? ASCII_LF : r_byte;
  assign w_pop       = r_out_valid && out_ready;
  assign w_rd_next   = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + LW'(1);
      2'b01:   w_count_next = r_count - LW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_char  <= 6'o00;
      r_byte  <= 8'h00;
      r_upper <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tyo_strobe) begin
            r_char  <= tyo_char;
            r_busy  <= 1'b1;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_byte <= w_ascii;
          // Shift codes update the case even when output is discarded.
          if ((r_char == FD_LOWER) || (r_char == FD_UPPER) || !w_mapped || !enable) begin
            if (r_char == FD_LOWER) begin
              r_upper <= 1'b0;
            end else if (r_char == FD_UPPER) begin
              r_upper <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (!w_full) begin
            if ((r_char == FD_CR) && CRLF) begin
              r_state <= ST_PUSH_LF;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_PUSH_LF: begin
          if (!w_full) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Head register is loaded with next cycle's head; bypass covers a push into the slot being exposed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_out_data <= (w_push && (r_wr_ptr == w_rd_next)) ? w_push_data : r_mem[w_rd_next];
      end
    end
  end

  assign tyo_busy   = r_busy;
  assign tyo_done   = r_done;
  assign upper_case = r_upper;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign fifo_level = r_count;

endmodule
